// File: rtl/pwm_decoder_pkg.sv
// pwm_decoder_pkg: shared PWM duty-code encodings, quantization thresholds and decoder states
package pwm_decoder_pkg;

    typedef enum logic [2:0] {
        DUTY_0, DUTY_25, DUTY_37P5, DUTY_50, DUTY_62P5, DUTY_75, DUTY_87P5, DUTY_100
    } duty_t;

    typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} state_t;

    // Midpoints between adjacent duty levels, in sixteenths of a period
    localparam logic [6:0][3:0] THRESH = {4'd15, 4'd13, 4'd11, 4'd9, 4'd7, 4'd5, 4'd2};

    function automatic duty_t duty_of(input logic [27:0] high, input logic [27:0] period);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 7; i++)
            n = n + 3'({high, 4'b0} >= 32'(THRESH[i]) * 32'(period));
        return duty_t'(n);
    endfunction

endpackage

// File: rtl/pwm_decoder_sync_edge_detect.sv
// sync_edge_detect: two-flop synchronizer plus a history flop for rise/fall detection
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) {s1_q, s2_q, s3_q} <= '0;
        else       {s1_q, s2_q, s3_q} <= {async_in, s1_q, s2_q};
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures period, high time and quantized duty of an asynchronous PWM input
module pwm_decoder
    import pwm_decoder_pkg::*;
#(
    parameter logic [27:0] PERIOD  = 28'd500000,
    parameter logic [27:0] TIMEOUT = 28'd1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [27:0] period_ticks,
    output logic [27:0] high_ticks,
    output logic [2:0]  duty_code,
    output logic        valid,
    output logic        timeout
);

    if (TIMEOUT <= PERIOD) begin : g_timeout_check
        $error("TIMEOUT must exceed the nominal PWM PERIOD");
    end

    state_t      state_q, state_d;
    duty_t       duty_q, duty_d;
    logic [27:0] cnt_q, cnt_d, hf_q, hf_d, period_q, period_d, high_q, high_d;
    logic        valid_q, valid_d, timeout_q, timeout_d;
    logic        level, rise, fall;

    sync_edge_detect u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (pwm_in),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_RISE;
            cnt_q     <= '0;
            hf_q      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= DUTY_0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hf_q      <= hf_d;
            period_q  <= period_d;
            high_q    <= high_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // cnt passes TIMEOUT exactly once per rise-free stretch, so the equality fires once
    always_comb begin
        state_d   = state_q;
        cnt_d     = rise ? 28'd1 : (&cnt_q ? cnt_q : cnt_q + 28'd1);
        hf_d      = hf_q;
        period_d  = period_q;
        high_d    = high_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (rise) begin
            state_d = HIGH;
            if (state_q == LOW) begin
                period_d  = cnt_q;
                high_d    = hf_q;
                duty_d    = duty_of(hf_q, cnt_q);
                valid_d   = 1'b1;
                timeout_d = 1'b0;
            end
        end else if (cnt_q == TIMEOUT) begin
            state_d = WAIT_RISE;
            if (!timeout_q) begin
                period_d  = '0;
                high_d    = '0;
                duty_d    = level ? DUTY_100 : DUTY_0;
                valid_d   = 1'b1;
                timeout_d = 1'b1;
            end
        end else if (fall && state_q == HIGH) begin
            hf_d    = cnt_q;
            state_d = LOW;
        end
    end

    assign period_ticks = period_q;
    assign high_ticks   = high_q;
    assign duty_code    = duty_q;
    assign valid        = valid_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: table-driven, directed and random checks against a timestamp reference model
module tb_pwm_decoder;

    localparam int TMO = 1000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pwm_in = 1'b0;
    logic [27:0] period_ticks, high_ticks;
    logic [2:0]  duty_code;
    logic        valid, timeout;

    pwm_decoder #(.PERIOD(28'd400), .TIMEOUT(28'd1000)) dut (
        .clock        (clock),
        .reset        (reset),
        .pwm_in       (pwm_in),
        .period_ticks (period_ticks),
        .high_ticks   (high_ticks),
        .duty_code    (duty_code),
        .valid        (valid),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int vcnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        pwm_in = v;
        repeat (n) begin
            @(negedge clock);
            vcnt += int'(valid);
        end
    endtask

    function automatic logic [2:0] quant(input int hi, input int per);
        int th[7] = '{2, 5, 7, 9, 11, 13, 15};
        int n = 0;
        foreach (th[i]) if (16 * hi >= th[i] * per) n++;
        return 3'(n);
    endfunction

    // Reference model: works on timestamps of synchronized edges (sample edge + 2)
    int          t, r_t, f_t, anchor;
    logic [2:0]  hist;
    logic [27:0] e_per, e_high;
    logic [2:0]  e_duty;
    logic        e_valid, e_tmo;

    initial forever begin
        @(posedge clock);
        if (reset) begin
            t = 0; anchor = 1; r_t = -1; f_t = -1; hist = '0;
            e_per = '0; e_high = '0; e_duty = '0; e_valid = 1'b0; e_tmo = 1'b0;
        end else begin
            t++;
            e_valid = 1'b0;
            if (hist[1] && !hist[2]) begin
                if (r_t >= 0 && f_t > r_t) begin
                    e_per   = 28'(t - r_t);
                    e_high  = 28'(f_t - r_t);
                    e_duty  = quant(f_t - r_t, t - r_t);
                    e_valid = 1'b1;
                    e_tmo   = 1'b0;
                end
                r_t = t; f_t = -1; anchor = t;
            end else if (t - anchor == TMO) begin
                if (!e_tmo) begin
                    e_per = '0; e_high = '0; e_duty = hist[1] ? 3'b111 : 3'b000;
                    e_valid = 1'b1; e_tmo = 1'b1;
                end
                r_t = -1; f_t = -1;
            end else if (!hist[1] && hist[2] && r_t >= 0 && f_t < 0) begin
                f_t = t;
            end
            hist = {hist[1:0], pwm_in};
        end
    end

    initial forever begin
        @(negedge clock);
        if (!reset)
            chk($sformatf("cycle@%0t", $time),
                64'({period_ticks, high_ticks, duty_code, valid, timeout}),
                64'({e_per, e_high, e_duty, e_valid, e_tmo}));
    end

    typedef struct {
        int          h;
        int          l;
        logic [27:0] per;
        logic [27:0] hi;
        logic [2:0]  duty;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{200, 200, 28'd400,  28'd200, 3'b011},
            '{100, 300, 28'd400,  28'd100, 3'b001},
            '{350,  50, 28'd400,  28'd350, 3'b110},
            '{ 10, 390, 28'd400,  28'd10,  3'b000},
            '{150, 250, 28'd400,  28'd150, 3'b010},
            '{250, 150, 28'd400,  28'd250, 3'b100},
            '{300, 100, 28'd400,  28'd300, 3'b101},
            '{390,  10, 28'd400,  28'd390, 3'b111},
            '{400, 400, 28'd800,  28'd400, 3'b011},
            '{500, 500, 28'd1000, 28'd500, 3'b011}
        };
        repeat (3) @(negedge clock);
        chk("reset_state", 64'({period_ticks, high_ticks, duty_code, valid, timeout}), 64'(0));
        reset = 1'b0;

        foreach (vecs[i]) begin
            hold(1'b1, vecs[i].h); hold(1'b0, vecs[i].l);
            hold(1'b1, vecs[i].h); hold(1'b0, vecs[i].l);
            hold(1'b1, 3);
            chk($sformatf("row%0d_period", i), 64'(period_ticks), 64'(vecs[i].per));
            chk($sformatf("row%0d_high", i), 64'(high_ticks), 64'(vecs[i].hi));
            chk($sformatf("row%0d_duty", i), 64'(duty_code), 64'(vecs[i].duty));
            chk($sformatf("row%0d_timeout", i), 64'(timeout), 64'(0));
        end

        hold(1'b1, 200); hold(1'b0, 200);
        pwm_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("edge_n%0d_valid", i + 1), 64'(valid), 64'(i == 2));
        end

        hold(1'b1, 196);
        vcnt = 0;
        hold(1'b0, 1200);
        chk("stuck_low_valids", 64'(vcnt), 64'(1));
        chk("stuck_low_timeout", 64'(timeout), 64'(1));
        chk("stuck_low_outputs", 64'({period_ticks, high_ticks, duty_code}), 64'(0));

        vcnt = 0;
        hold(1'b1, 1200);
        chk("after_timeout_valids", 64'(vcnt), 64'(0));
        chk("after_timeout_level", 64'({duty_code, timeout}), 64'({3'b000, 1'b1}));

        hold(1'b0, 200); hold(1'b1, 200); hold(1'b0, 200); hold(1'b1, 5);
        chk("recover_timeout", 64'(timeout), 64'(0));
        chk("recover_period", 64'({period_ticks, high_ticks}), 64'({28'd400, 28'd200}));
        vcnt = 0;
        hold(1'b1, 1200);
        chk("stuck_high_valids", 64'(vcnt), 64'(1));
        chk("stuck_high_outputs", 64'({period_ticks, high_ticks, duty_code, timeout}),
            64'({28'd0, 28'd0, 3'b111, 1'b1}));

        hold(1'b0, 200); hold(1'b1, 200); hold(1'b0, 200); hold(1'b1, 50);
        reset = 1'b1;
        #1;
        chk("reset_immediate", 64'({period_ticks, high_ticks, duty_code, valid, timeout}), 64'(0));
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        vcnt = 0;
        hold(1'b1, 150); hold(1'b0, 200);
        chk("reset_no_early_valid", 64'(vcnt), 64'(0));
        hold(1'b1, 3);
        chk("reset_first_valid", 64'(vcnt), 64'(1));
        chk("reset_first_meas", 64'({period_ticks, high_ticks, duty_code}),
            64'({28'd350, 28'd150, 3'b010}));

        for (int k = 0; k < 24; k++) begin
            hold(1'b1, $urandom_range(1, 600));
            hold(1'b0, $urandom_range(1, 600));
            if ($urandom_range(0, 4) == 0) hold(1'($urandom_range(0, 1)), $urandom_range(900, 1100));
        end
        hold(1'b1, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 Parameter PERIOD, default 28'd500000, nominal PWM period in clock ticks; bench scaling only, not used in measurement.
REQ-002 Parameter TIMEOUT, default 28'd1000000, edge-free ticks before the input is declared stuck.
REQ-003 clock  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pwm_in  input  1  asynchronous PWM waveform to be measured.
REQ-006 period_ticks  output  28  last measured period in clock ticks, rise to rise.
REQ-007 high_ticks  output  28  last measured high time in clock ticks, rise to fall.
REQ-008 duty_code  output  3  quantized duty, same encoding as the team's PWM generator: 000=0%, 001=25%, 010=37.5%, 011=50%, 100=62.5%, 101=75%, 110=87.5%, 111=100%.
REQ-009 valid  output  1  one-cycle strobe when the measurement outputs update.
REQ-010 timeout  output  1  level; high while the input is considered stuck.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer, then a third flop for edge detection; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-012 FSM states: WAIT_RISE (no reference rise yet), HIGH (after rise, before fall), LOW (after fall, before next rise).
REQ-013 Tick counter cnt (28 bit) SHALL load 1 on a detected rise, otherwise increment, saturating at all-ones.
REQ-014 WAIT_RISE: rise -> HIGH with no output update; falls ignored.
REQ-015 HIGH: fall -> capture hf <= cnt internally, go LOW.
REQ-016 LOW: rise -> period_ticks <= cnt, high_ticks <= hf, duty_code updated, valid=1 for one cycle, timeout <= 0, go HIGH.
REQ-017 Latency: if pwm_in is first sampled high at clock edge N, the registered valid SHALL be high after edge N+2, for exactly one cycle.
REQ-018 duty_code SHALL be the number of thresholds t in {2,5,7,9,11,13,15} satisfying 16*high >= t*period (nearest-level rounding, no divider); comparison width 32 bits.
REQ-019 Timeout: if cnt reaches TIMEOUT in any state without an edge, duty_code <= 111 if s2=1 else 000, period_ticks <= 0, high_ticks <= 0, valid pulses once, timeout <= 1, go WAIT_RISE.
REQ-020 While timeout=1 no further valid pulses SHALL occur until a full rise-fall-rise cycle completes.
REQ-021 A rise and the TIMEOUT count coinciding on the same edge: the edge SHALL win (normal measurement path).
REQ-022 Outputs SHALL hold their last values between valid strobes.

Reset
REQ-023 On reset: state WAIT_RISE, synchronizer flops 0, cnt 0, hf 0, period_ticks 0, high_ticks 0, duty_code 000, valid 0, timeout 0.
REQ-024 Reset asserted mid-measurement SHALL discard the partial measurement; the first valid after release requires two rises.

Structure
REQ-025 Duty-code encodings and the threshold constants {2,5,7,9,11,13,15} SHALL live in the shared PWM definitions include used by the generator.
REQ-026 Synchronizer plus edge detection SHALL be a sub-module sync_edge_detect (ports clock, reset, async_in, level, rise, fall).

Verification (PERIOD=400, TIMEOUT=1000)
REQ-027 Square wave, 200 high / 200 low -> from second rise: period_ticks=400, high_ticks=200, duty_code=011, valid one cycle per period.
REQ-028 100 high / 300 low -> high_ticks=100, duty_code=001; 350 high / 50 low -> duty_code=110 (87.5%).
REQ-029 pwm_in held low 1200 cycles after running -> timeout=1, duty_code=000, one valid; held high instead -> duty_code=111.
REQ-030 Reset pulsed mid-HIGH -> all outputs 0 immediately; no valid until two full rises after release.
REQ-031 Edge timing: pwm_in rises at edge N -> valid seen after edge N+2 exactly, never at N+1 or N+3.
